// File: rtl/apb_pkg.sv
// apb_pkg: shared FSM encoding and defaults for the APB master.
package apb_pkg;
    localparam int APB_TIMEOUT_DEFAULT = 16;
    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;
endpackage

// File: rtl/apb_if.sv
// apb_if: APB bus signals with master and slave views.
interface apb_if;
    logic sel, enable, write, ready, slverr;
    logic [31:0] addr, wdata, rdata;
    logic [3:0] strb;
    modport master(output sel, enable, write, addr, wdata, strb, input rdata, ready, slverr);
    modport slave(input sel, enable, write, addr, wdata, strb, output rdata, ready, slverr);
endinterface

// File: rtl/apb_master.sv
// apb_master: turns a valid/ready request into one APB transfer with a bounded wait-state budget.
module apb_master
    import apb_pkg::*;
#(
    parameter int TIMEOUT = APB_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_strb,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        resp_timeout,
    apb_if.master       apb
);
    localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
    state_t state, state_n;
    logic [CW-1:0] cnt;
    logic accept, done, expired;
    logic write_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0] strb_q;
    assign apb.sel = state != IDLE;
    assign apb.enable = state == ACCESS;
    assign apb.write = write_q;
    assign apb.addr = addr_q;
    assign apb.wdata = wdata_q;
    assign apb.strb = strb_q;
    always_ff @(posedge clk) state <= rst ? IDLE : state_n;
    always_comb begin
        req_ready = state == IDLE && (!resp_valid || resp_ready);
        accept = req_valid && req_ready;
        done = state == ACCESS && apb.ready;
        // a ready in the same cycle the budget runs out still counts as a normal completion
        expired = TIMEOUT > 0 && state == ACCESS && !apb.ready && cnt == CW'(TIMEOUT);
        state_n = state == IDLE ? (accept ? SETUP : IDLE) :
                  state == SETUP ? ACCESS :
                  (done || expired) ? IDLE : ACCESS;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            write_q <= 1'b0;
            addr_q <= '0;
            wdata_q <= '0;
            strb_q <= '0;
            cnt <= '0;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err <= 1'b0;
            resp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                write_q <= req_write;
                addr_q <= req_addr;
                strb_q <= req_write ? req_strb : 4'h0;
                if (req_write) wdata_q <= req_wdata;
            end
            cnt <= (state == ACCESS && !apb.ready) ? cnt + 1'b1 : '0;
            if (done || expired) begin
                resp_valid <= 1'b1;
                resp_rdata <= (done && !write_q) ? apb.rdata : '0;
                resp_err <= !done || apb.slverr;
                resp_timeout <= !done;
            end else if (resp_ready) begin
                resp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_apb_master.sv
// tb_apb_master: random APB transfers checked against a word-level memory and cycle-count reference.
module tb_apb_master;
    import apb_pkg::*;
    localparam int TO = 4;
    logic clk = 1'b0, rst = 1'b1;
    logic req_valid = 1'b0, req_write = 1'b0, resp_ready = 1'b1;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [3:0] req_strb = '0;
    logic req_ready, resp_valid, resp_err, resp_timeout;
    logic [31:0] resp_rdata;
    int checks = 0, errors = 0;
    logic [31:0] smem [16] = '{default: 32'h0};
    logic [31:0] model [16];
    logic [31:0] last_wd = '0;
    int wait_n = 0;
    logic err_en = 1'b0;
    logic [7:0] acnt = '0;
    apb_if apb ();
    apb_master #(.TIMEOUT(TO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
        .resp_err(resp_err), .resp_timeout(resp_timeout), .apb(apb)
    );
    always #5 clk = ~clk;
    // behavioural slave: 16-word memory, wait_n wait states, optional error (errored writes are dropped)
    assign apb.ready = apb.sel && apb.enable && int'(acnt) >= wait_n;
    assign apb.slverr = apb.ready && err_en;
    assign apb.rdata = apb.ready ? smem[apb.addr[5:2]] : 32'hBADC0DE5;
    always @(posedge clk) begin
        acnt <= (apb.sel && apb.enable && !apb.ready) ? acnt + 8'd1 : 8'd0;
        if (apb.ready && apb.write && !err_en)
            for (int b = 0; b < 4; b++)
                if (apb.strb[b]) smem[apb.addr[5:2]][8*b +: 8] <= apb.wdata[8*b +: 8];
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask
    task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                        input int waits, input logic e, input int hold);
        logic to, exp_err;
        logic [31:0] exp_rd;
        int acc, n;
        to = waits > TO;
        exp_err = to || e;
        exp_rd = (w || to) ? 32'h0 : model[a[5:2]];
        if (w && !to && !e)
            for (int b = 0; b < 4; b++) if (s[b]) model[a[5:2]][8*b +: 8] = d[8*b +: 8];
        wait_n = waits;
        err_en = e;
        req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_strb = s;
        n = 0;
        #1;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("accept", n < 50, 1);
        @(negedge clk);
        req_valid = 1'b0; req_write = ~w; req_addr = $urandom(); req_wdata = $urandom(); req_strb = 4'($urandom());
        check("setup_phase", {apb.sel, apb.enable}, 2'b10);
        check("setup_write", apb.write, w);
        check("setup_addr", apb.addr, a);
        check("setup_strb", apb.strb, w ? s : 4'h0);
        check("setup_wdata", apb.wdata, w ? d : last_wd);
        if (w) last_wd = d;
        acc = 0;
        @(negedge clk);
        while (apb.sel && apb.enable && acc < 40) begin
            check("access_addr", apb.addr, a);
            check("access_strb", apb.strb, w ? s : 4'h0);
            check("access_wdata", apb.wdata, last_wd);
            acc++;
            @(negedge clk);
        end
        check("access_cycles", acc, to ? TO + 1 : waits + 1);
        check("done_sel", {apb.sel, apb.enable}, 2'b00);
        check("resp_valid", resp_valid, 1);
        check("resp_rdata", resp_rdata, exp_rd);
        check("resp_err", resp_err, exp_err);
        check("resp_timeout", resp_timeout, to);
        resp_ready = hold == 0;
        #1 check("req_ready_done", req_ready, hold == 0);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            check("hold_req_ready", req_ready, 0);
            check("hold_valid", resp_valid, 1);
            check("hold_rdata", resp_rdata, exp_rd);
            check("hold_flags", {resp_err, resp_timeout}, {exp_err, to});
        end
        resp_ready = 1'b1;
        #1 check("req_ready_release", req_ready, 1);
        @(negedge clk);
        check("resp_clear", resp_valid, 0);
    endtask
    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end
    initial begin
        logic w, e;
        int r;
        foreach (model[i]) model[i] = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_bus", {apb.sel, apb.enable, apb.write}, 3'b000);
        check("rst_addr", apb.addr, 0);
        check("rst_wdata", apb.wdata, 0);
        check("rst_strb", apb.strb, 0);
        check("rst_resp", {resp_valid, resp_err, resp_timeout}, 3'b000);
        check("rst_rdata", resp_rdata, 0);
        check("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        @(negedge clk);
        xfer(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0, 0);
        check("slave_word4", smem[4], 32'hDEADBEEF);
        xfer(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0, 0);
        xfer(1'b1, 32'h20, 32'h12345678, 4'hF, 3, 1'b0, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 100, 1'b0, 0);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, TO, 1'b0, 1);
        xfer(1'b1, 32'h20, 32'hA5A5A5A5, 4'h5, 1, 1'b0, 5);
        xfer(1'b0, 32'h20, 32'h0, 4'h0, 2, 1'b1, 2);
        xfer(1'b1, 32'h24, 32'hFFFFFFFF, 4'hF, 0, 1'b1, 0);
        // reset in ACCESS abandons a write that the slave never acknowledges
        wait_n = 1000;
        err_en = 1'b0;
        req_valid = 1'b1; req_write = 1'b1; req_addr = 32'h28; req_wdata = 32'hCAFEF00D; req_strb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("rst_mid_access", {apb.sel, apb.enable}, 2'b11);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("rst_mid_bus", {apb.sel, apb.enable}, 2'b00);
        check("rst_mid_resp", resp_valid, 0);
        check("rst_mid_addr", apb.addr, 0);
        last_wd = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            check("rst_mid_noresp", {resp_valid, apb.sel}, 2'b00);
        end
        for (int i = 0; i < 40; i++) begin
            w = 1'($urandom_range(0, 1));
            r = $urandom_range(0, 9);
            e = $urandom_range(0, 4) == 0;
            xfer(w, $urandom(), $urandom(), 4'($urandom()), r > 6 ? 20 : r, e, $urandom_range(0, 3));
        end
        foreach (model[i]) check($sformatf("mem_%0d", i), smem[i], model[i]);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 Parameter TIMEOUT, default 16, SHALL be the ACCESS-phase wait-state limit in cycles; 0 disables the timeout.
REQ-002 Port clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 Port rst  input  1  SHALL be the synchronous, active-high reset.
REQ-004 Port req_valid  input  1  SHALL indicate a transfer request is presented.
REQ-005 Port req_ready  output  1  SHALL indicate the block accepts the request this cycle.
REQ-006 Port req_write  input  1  SHALL select write (1) or read (0).
REQ-007 Port req_addr  input  32  SHALL be the byte address, forwarded unmodified.
REQ-008 Port req_wdata  input  32  SHALL be the write data.
REQ-009 Port req_strb  input  4  SHALL be the write byte strobes.
REQ-010 Port resp_valid  output  1  SHALL indicate a completed transfer result is held.
REQ-011 Port resp_ready  input  1  SHALL indicate the consumer takes the response.
REQ-012 Port resp_rdata  output  32  SHALL be the read data, 0 for writes.
REQ-013 Port resp_err  output  1  SHALL be set on slave error or timeout.
REQ-014 Port resp_timeout  output  1  SHALL be set only when the transfer ended by timeout.
REQ-015 Port apb  apb_if.master  -  SHALL drive sel, enable, write, addr, wdata, strb and sample rdata, ready, slverr.

Function
REQ-016 The FSM SHALL have states IDLE, SETUP, ACCESS.
REQ-017 req_ready SHALL equal (state==IDLE) && (!resp_valid || resp_ready).
REQ-018 On req_valid && req_ready, the request SHALL be registered and the state SHALL move to SETUP.
REQ-019 In SETUP, sel=1 and enable=0; the next state SHALL unconditionally be ACCESS.
REQ-020 In ACCESS, sel=1 and enable=1; addr, write, wdata and strb SHALL stay stable from SETUP until completion.
REQ-021 The transfer SHALL complete at the ACCESS cycle where apb.ready=1; rdata (reads only) and slverr SHALL be captured, resp_valid set, and the state SHALL go to IDLE.
REQ-022 Minimum latency: request accepted at edge N, SETUP in cycle N+1, ACCESS in N+2, resp_valid high in N+3.
REQ-023 The wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle with ready=0.
REQ-024 If TIMEOUT>0 and the counter reaches TIMEOUT with ready still 0, the block SHALL complete with resp_err=1, resp_timeout=1, resp_rdata=0, and deassert sel/enable.
REQ-025 If ready=1 in the cycle the counter reaches TIMEOUT, normal completion SHALL take priority.
REQ-026 For reads, strb SHALL be driven 4'b0000 and wdata held at its last value.
REQ-027 In IDLE, sel and enable SHALL be 0; addr, write, wdata and strb SHALL hold their last values.
REQ-028 resp_* SHALL stay stable while resp_valid && !resp_ready; resp_valid SHALL clear on resp_ready unless a new completion occurs that same cycle.
REQ-029 After completion the block SHALL pass through IDLE; no direct ACCESS-to-SETUP chaining.
REQ-030 apb.rdata SHALL be sampled only when sel && enable && ready && !write.

Reset
REQ-031 On rst: state=IDLE, sel=0, enable=0, write=0, addr=0, wdata=0, strb=0, resp_valid=0, resp_rdata=0, resp_err=0, resp_timeout=0, counter=0.
REQ-032 Reset asserted mid-transfer SHALL abandon the transfer with no response generated; the next cycle drives IDLE values.

Structure
REQ-033 The state enum and the APB_TIMEOUT_DEFAULT constant SHALL reside in the shared package apb_pkg.
REQ-034 The block SHALL be a single module with no sub-module; the counter width SHALL be $clog2(TIMEOUT+1).

Verification
REQ-035 Write 0x10 data 0xDEADBEEF strb 4'hF to apb_slave (SIZE=64) -> SETUP then ACCESS, resp_valid at N+3 with resp_err=0, and slave word 4 = 0xDEADBEEF.
REQ-036 Read 0x10 after the write -> resp_rdata=0xDEADBEEF, strb=0 during both phases.
REQ-037 Slave holding ready=0 for 3 cycles, TIMEOUT=16 -> ACCESS lasts 4 cycles, stable addr, resp_err=0.
REQ-038 Slave never asserting ready, TIMEOUT=4 -> resp_err=1, resp_timeout=1, resp_rdata=0, sel drops.
REQ-039 resp_ready held 0 for 5 cycles after completion -> req_ready=0, response stable; the second request is accepted in the cycle resp_ready=1.
REQ-040 rst asserted in ACCESS -> next cycle sel=0, enable=0, resp_valid=0, no response ever emitted.
